sprite_line_fetch: RTL

SPRITE_LINE_FETCH -- requirements
Module: sprite_line_fetch

---
 rtl/sprite_line_fetch_pkg.sv | 16 +
 rtl/sprite_line_fetch_buf.sv | 25 ++
 rtl/sprite_line_fetch.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sprite_line_fetch_pkg.sv
// Shared constants and FSM encoding for the sprite line prefetcher.
package sprite_line_fetch_pkg;

   localparam int          DEF_SPR_LEN     = 16;
   localparam logic [11:0] DEF_TRANSPARENT = 12'hCBE;
   localparam logic [11:0] DEF_BG_COLOR    = 12'hFFF;
   localparam int          ROM_AW          = 17;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FETCH = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/sprite_line_fetch_buf.sv
// One sprite's worth of pixels for the upcoming line: write by fetch column, read by screen column.
module spr_line_buf
   import sprite_line_fetch_pkg::*;
#(
   parameter int SPR_LEN = DEF_SPR_LEN,
   parameter int COL_W   = $clog2(SPR_LEN)
) (
   input  logic             pclk,
   input  logic             wr_en_i,
   input  logic [COL_W-1:0] wr_col_i,
   input  logic [11:0]      wr_data_i,
   input  logic [COL_W-1:0] rd_col_i,
   output logic [11:0]      rd_data_o
);

   // Contents are not reset; stale data is masked by the slot hit flags.
   logic [11:0] mem_q [SPR_LEN];

   always_ff @(posedge pclk) begin
      if (wr_en_i) mem_q[wr_col_i] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_col_i];

endmodule

// File: rtl/sprite_line_fetch.sv
// Prefetches the next scanline of up to NUM_SPR sprites from ROM during blanking,
// then composites them against h_cnt with a registered pixel output.
module sprite_line_fetch
   import sprite_line_fetch_pkg::*;
#(
   parameter int          NUM_SPR     = 4,
   parameter int          SPR_LEN     = DEF_SPR_LEN,
   parameter logic [11:0] TRANSPARENT = DEF_TRANSPARENT,
   parameter logic [11:0] BG_COLOR    = DEF_BG_COLOR
) (
   input  logic                  pclk,
   input  logic                  reset,
   input  logic                  line_start,
   input  logic [9:0]            next_line,
   input  logic [NUM_SPR-1:0]    spr_en,
   input  logic [10*NUM_SPR-1:0] spr_r,
   input  logic [10*NUM_SPR-1:0] spr_c,
   input  logic [8*NUM_SPR-1:0]  spr_id,
   output logic [ROM_AW-1:0]     rom_addr,
   input  logic [11:0]           rom_data,
   input  logic [9:0]            h_cnt,
   input  logic                  valid,
   output logic [11:0]           pix_out,
   output logic                  pix_hit,
   output logic                  busy,
   output fetch_state_e          dbg_state
);

   localparam int COL_W  = (SPR_LEN > 1) ? $clog2(SPR_LEN) : 1;
   localparam int SLOT_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

   fetch_state_e       state_q;
   logic [9:0]         line_q;
   logic [NUM_SPR-1:0] hit_q;
   logic [9:0]         row_q [NUM_SPR];
   logic [9:0]         xpos_q [NUM_SPR];
   logic [7:0]         id_q [NUM_SPR];
   logic [SLOT_W-1:0]  slot_q;
   logic [COL_W-1:0]   col_q;
   logic               wr_en_q;
   logic [SLOT_W-1:0]  wr_slot_q;
   logic [COL_W-1:0]   wr_col_q;
   logic [11:0]        pix_q;
   logic               pix_hit_q;

   logic [NUM_SPR-1:0] load_hit;
   logic [9:0]         load_row [NUM_SPR];
   logic               last_col, last_slot;

   // Row within the sprite wraps modulo 1024, so rows above the sprite never hit.
   always_comb begin
      for (int i = 0; i < NUM_SPR; i++) begin
         load_row[i] = line_q - spr_r[10*i +: 10];
         load_hit[i] = spr_en[i] && (load_row[i] < 10'(SPR_LEN));
      end
   end

   assign last_col  = (col_q == COL_W'(SPR_LEN-1));
   assign last_slot = (slot_q == SLOT_W'(NUM_SPR-1));

   always_ff @(posedge pclk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         line_q    <= '0;
         hit_q     <= '0;
         slot_q    <= '0;
         col_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_slot_q <= '0;
         wr_col_q  <= '0;
      end else begin
         // ROM data lands one cycle after its address, so the write is delayed to match.
         wr_en_q   <= (state_q == ST_FETCH) && hit_q[slot_q];
         wr_slot_q <= slot_q;
         wr_col_q  <= col_q;
         if (line_start) begin
            state_q <= ST_LOAD;
            line_q  <= next_line;
         end else begin
            case (state_q)
               ST_LOAD: begin
                  for (int i = 0; i < NUM_SPR; i++) begin
                     row_q[i]  <= load_row[i];
                     xpos_q[i] <= spr_c[10*i +: 10];
                     id_q[i]   <= spr_id[8*i +: 8];
                  end
                  hit_q   <= load_hit;
                  slot_q  <= '0;
                  col_q   <= '0;
                  state_q <= ST_FETCH;
               end
               ST_FETCH: begin
                  if (hit_q[slot_q] && !last_col) begin
                     col_q <= col_q + 1'b1;
                  end else begin
                     col_q <= '0;
                     if (last_slot) state_q <= ST_DRAIN;
                     else           slot_q  <= slot_q + 1'b1;
                  end
               end
               ST_DRAIN: state_q <= ST_IDLE;
               default:  state_q <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      rom_addr = '0;
      if (state_q == ST_FETCH && hit_q[slot_q])
         rom_addr = ROM_AW'(id_q[slot_q]) * ROM_AW'(SPR_LEN*SPR_LEN)
                  + ROM_AW'(row_q[slot_q]) * ROM_AW'(SPR_LEN) + ROM_AW'(col_q);
   end

   logic [11:0]        rd_data [NUM_SPR];
   logic [NUM_SPR-1:0] cand;

   for (genvar g = 0; g < NUM_SPR; g++) begin : g_slot
      logic [10:0]      right_edge;
      logic [COL_W-1:0] rd_col;
      assign right_edge = {1'b0, xpos_q[g]} + 11'(SPR_LEN-1);
      assign rd_col     = COL_W'(h_cnt - xpos_q[g]);
      assign cand[g]    = hit_q[g] && (h_cnt >= xpos_q[g]) && ({1'b0, h_cnt} <= right_edge);

      spr_line_buf #(.SPR_LEN(SPR_LEN), .COL_W(COL_W)) u_buf (
         .pclk      (pclk),
         .wr_en_i   (wr_en_q && (wr_slot_q == SLOT_W'(g))),
         .wr_col_i  (wr_col_q),
         .wr_data_i (rom_data),
         .rd_col_i  (rd_col),
         .rd_data_o (rd_data[g])
      );
   end

   logic [11:0] comp_pix;
   logic        comp_hit;

   // Scan from the highest slot down so the lowest opaque slot is the last to claim the pixel.
   always_comb begin
      comp_pix = BG_COLOR;
      comp_hit = 1'b0;
      for (int i = NUM_SPR-1; i >= 0; i--) begin
         if (cand[i] && (rd_data[i] != TRANSPARENT)) begin
            comp_pix = rd_data[i];
            comp_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (reset || !valid) begin
         pix_q     <= 12'h000;
         pix_hit_q <= 1'b0;
      end else begin
         pix_q     <= comp_pix;
         pix_hit_q <= comp_hit;
      end
   end

   assign pix_out   = pix_q;
   assign pix_hit   = pix_hit_q;
   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

endmodule
